// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_LEFT,
    RX_RIGHT
  } rx_state_t;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  localparam int RX_FIFO_DEPTH = 4;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous show-ahead FIFO holding captured left/right pairs.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module i2s_rx_fifo
  import i2s_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = RX_FIFO_DEPTH
) (
  input  logic          MCLK,
  input  logic          nReset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count_reg != '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (!do_push && do_pop) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples SCLK/LRCLK/SD in the MCLK domain and emits {left, right} pairs.
// Define I2S_RX_FIFO_EN to replace the single holding register with a pair FIFO.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int MIN_SCLK_HALF = 3
) (
  input  logic               MCLK,
  input  logic               nReset,
  input  logic               onOff,
  input  logic               SCLK,
  input  logic               LRCLK,
  input  logic               SD,
  input  logic               Rx_Ready,
  output logic [2*WIDTH-1:0] Rx_Data,
  output logic               Rx_Valid,
  output logic               Overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam int HC_W = $clog2(MIN_SCLK_HALF + 1);

  logic [2:0] async_in;
  logic [2:0] sync_s;
  logic       sclk_s;
  logic       lr_s;
  logic       sd_s;
  logic       sclk_prev_reg;
  logic       bit_stb;

  assign async_in = {SD, LRCLK, SCLK};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic [1:0] meta_reg;
      always_ff @(posedge MCLK or negedge nReset) begin
        if (!nReset) meta_reg <= '0;
        else         meta_reg <= {meta_reg[0], async_in[gi]};
      end
      assign sync_s[gi] = meta_reg[1];
    end
  endgenerate

  assign sclk_s = sync_s[0];
  assign lr_s   = sync_s[1];
  assign sd_s   = sync_s[2];

  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) sclk_prev_reg <= 1'b0;
    else         sclk_prev_reg <= sclk_s;
  end

  assign bit_stb = sclk_s & ~sclk_prev_reg;

  // Framer
  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] word_reg, word_next;
  logic [WIDTH-1:0] left_reg, left_next;
  logic             lr_prev_reg, lr_prev_next;
  logic [WIDTH-1:0] word_wr;
  logic             emit;
  logic [2*WIDTH-1:0] pair_data;

  // Word with the current SD bit placed at [WIDTH-1-cnt]; unchanged once cnt saturates.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_wbit
      assign word_wr[gi] = (cnt_reg == CNT_W'(WIDTH - 1 - gi)) ? sd_s : word_reg[gi];
    end
  endgenerate

  assign pair_data = {left_reg, word_wr};

  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      state_reg   <= RX_IDLE;
      cnt_reg     <= '0;
      word_reg    <= '0;
      left_reg    <= '0;
      lr_prev_reg <= LR_LEFT;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      word_reg    <= word_next;
      left_reg    <= left_next;
      lr_prev_reg <= lr_prev_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    word_next    = word_reg;
    left_next    = left_reg;
    lr_prev_next = lr_prev_reg;
    emit         = 1'b0;
    if (!onOff) begin
      state_next   = RX_IDLE;
      cnt_next     = '0;
      word_next    = '0;
      left_next    = '0;
      lr_prev_next = LR_LEFT;
    end else if (bit_stb) begin
      lr_prev_next = lr_s;
      case (state_reg)
        RX_IDLE: begin
          if (lr_s == LR_LEFT && lr_prev_reg == LR_RIGHT) begin
            state_next = RX_LEFT;
            cnt_next   = '0;
            word_next  = '0;
          end
        end
        RX_LEFT, RX_RIGHT: begin
          if (lr_s == lr_prev_reg) begin
            word_next = word_wr;
            if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
          end else begin
            // One-bit delay: this SD bit is the LSB side of the closing word.
            cnt_next  = '0;
            word_next = '0;
            if (state_reg == RX_LEFT) begin
              left_next  = word_wr;
              state_next = RX_RIGHT;
            end else begin
              emit       = 1'b1;
              state_next = RX_LEFT;
            end
          end
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  // Output stage
  logic consume;
  logic room;
  logic overrun_reg;

`ifdef I2S_RX_FIFO_EN
  logic               fifo_valid;
  logic               fifo_full;
  logic [2*WIDTH-1:0] fifo_dout;

  i2s_rx_fifo #(
    .DW   (2*WIDTH),
    .DEPTH(RX_FIFO_DEPTH)
  ) u_fifo (
    .MCLK  (MCLK),
    .nReset(nReset),
    .flush (~onOff),
    .push  (emit),
    .pop   (Rx_Ready),
    .din   (pair_data),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign consume  = fifo_valid & Rx_Ready;
  assign room     = ~fifo_full | consume;
  assign Rx_Data  = fifo_dout;
  assign Rx_Valid = fifo_valid;
`else
  logic               rx_valid_reg;
  logic [2*WIDTH-1:0] rx_data_reg;

  assign consume = rx_valid_reg & Rx_Ready;
  assign room    = ~rx_valid_reg | consume;

  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset) begin
      rx_valid_reg <= 1'b0;
      rx_data_reg  <= '0;
    end else if (!onOff) begin
      rx_valid_reg <= 1'b0;
    end else if (emit && room) begin
      rx_valid_reg <= 1'b1;
      rx_data_reg  <= pair_data;
    end else if (consume) begin
      rx_valid_reg <= 1'b0;
    end
  end

  assign Rx_Data  = rx_data_reg;
  assign Rx_Valid = rx_valid_reg;
`endif

  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset)           overrun_reg <= 1'b0;
    else if (!onOff)       overrun_reg <= 1'b0;
    else if (emit && !room) overrun_reg <= 1'b1;
  end

  assign Overrun = overrun_reg;

  // Length of the SCLK level that just ended, saturating at MIN_SCLK_HALF.
  logic [HC_W-1:0] half_cnt_reg;

  always_ff @(posedge MCLK or negedge nReset) begin
    if (!nReset)
      half_cnt_reg <= HC_W'(MIN_SCLK_HALF);
    else if (sclk_s != sclk_prev_reg)
      half_cnt_reg <= HC_W'(1);
    else if (half_cnt_reg != HC_W'(MIN_SCLK_HALF))
      half_cnt_reg <= half_cnt_reg + 1'b1;
  end

  sclk_min_half: assert property (@(posedge MCLK) disable iff (!nReset)
    (sclk_s != sclk_prev_reg) |-> (half_cnt_reg >= HC_W'(MIN_SCLK_HALF)));

endmodule
